// File: rtl/fir_out_serializer_if.sv
// Sample-in / byte-out handshake bundle for fir_out_serializer.
// master: the serializer (drives the byte stream); slave: the FIR source and byte consumer.
interface fir_out_serializer_if #(
  parameter int unsigned Y_N_SIZE = 14
);
  logic [Y_N_SIZE-1:0] y_n;
  logic                y_valid;
  logic [7:0]          uo_data;
  logic                uo_valid;
  logic                uo_ready;
  logic                uo_last;

  modport master (
    input  y_n,
    input  y_valid,
    input  uo_ready,
    output uo_data,
    output uo_valid,
    output uo_last
  );

  modport slave (
    output y_n,
    output y_valid,
    output uo_ready,
    input  uo_data,
    input  uo_valid,
    input  uo_last
  );
endinterface

// File: rtl/fir_out_serializer.sv
// Buffers signed FIR samples in a small FIFO and emits each one as a HI then LO byte.
// Optional macro FIR_OUT_DROP_CNT_EN builds a saturating dropped-sample counter on drop_cnt.
module fir_out_serializer #(
  parameter int unsigned Y_N_SIZE   = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fir_out_serializer_if.master  bus,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_e;

  state_e                      state_q;
  logic [PW-1:0]               wptr_q, wptr_d;
  logic [PW-1:0]               rptr_q, rptr_d;
  logic                        full_q, empty_q;
  logic [Y_N_SIZE-1:0]         mem_q [FIFO_DEPTH];
  logic [7:0]                  hold_lo_q;
  logic [7:0]                  data_q;
  logic                        valid_q;
  logic                        last_q;
  logic                        ovf_q, ovf_d;

  logic                        hs_c;
  logic                        push_c;
  logic                        drop_c;
  logic                        pop_c;
  logic signed [Y_N_SIZE-1:0]  head_c;
  logic [15:0]                 head_s16_c;

  // Handshake, FIFO control and head-of-queue sign extension
  always_comb begin
    hs_c       = valid_q && bus.uo_ready;
    push_c     = bus.y_valid && !full_q;
    drop_c     = bus.y_valid && full_q;
    pop_c      = !empty_q && ((state_q == IDLE) || ((state_q == LO) && hs_c));
    head_c     = mem_q[rptr_q[AW-1:0]];
    head_s16_c = 16'(head_c);
    wptr_d     = wptr_q + PW'(push_c);
    rptr_d     = rptr_q + PW'(pop_c);
    ovf_d      = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop_c) begin
      ovf_d = 1'b1;
    end
  end

  // Sample storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q[AW-1:0]] <= bus.y_n;
    end
  end

  // Pointers with registered full/empty flags and the sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
      empty_q <= (wptr_d == rptr_d);
      ovf_q   <= ovf_d;
    end
  end

  // Byte sequencer: the HI byte is loaded on pop, the LO byte is kept in hold_lo_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_lo_q <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_c) begin
            hold_lo_q <= head_s16_c[7:0];
            data_q    <= head_s16_c[15:8];
            valid_q   <= 1'b1;
            last_q    <= 1'b0;
            state_q   <= HI;
          end
        end
        HI: begin
          if (hs_c) begin
            data_q  <= hold_lo_q;
            last_q  <= 1'b1;
            state_q <= LO;
          end
        end
        LO: begin
          if (hs_c) begin
            if (pop_c) begin
              hold_lo_q <= head_s16_c[7:0];
              data_q    <= head_s16_c[15:8];
              last_q    <= 1'b0;
              state_q   <= HI;
            end else begin
              data_q  <= 8'h00;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          data_q  <= 8'h00;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FIR_OUT_DROP_CNT_EN
  logic [7:0] dcnt_q, dcnt_d;

  // A drop coinciding with a clear leaves the count at one
  always_comb begin
    dcnt_d = dcnt_q;
    if (clr_ovf) begin
      dcnt_d = drop_c ? 8'd1 : 8'd0;
    end else if (drop_c && (dcnt_q != 8'hFF)) begin
      dcnt_d = dcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dcnt_q <= 8'h00;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign drop_cnt = dcnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

  assign bus.uo_data  = data_q;
  assign bus.uo_valid = valid_q;
  assign bus.uo_last  = last_q;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Scoreboard bench for fir_out_serializer: sample-level queue model predicts bytes and flags.
module tb_fir_out_serializer;

  localparam int unsigned YW    = 14;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       fifo_full, fifo_empty, overflow;
  logic [7:0] drop_cnt;

  fir_out_serializer_if #(.Y_N_SIZE(YW)) bus ();

  fir_out_serializer #(.Y_N_SIZE(YW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of samples, plus bytes still owed for the held sample
  int m_fq[$];
  int m_rem;
  int m_ovf;
  int m_dcnt;
  int exp_q[$];   // {last, data} in expected output order

  function automatic int s16(input int y);
    int v;
    v = y & ((1 << YW) - 1);
    if (v >= (1 << (YW - 1))) v = v - (1 << YW);
    return v & 16'hFFFF;
  endfunction

  function automatic int exp_dcnt();
`ifdef FIR_OUT_DROP_CNT_EN
    return m_dcnt;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin : model
    int  sz, v;
    bit  hs, wr, drop, pop;
    if (!reset_n) begin
      m_fq.delete();
      exp_q.delete();
      m_rem  = 0;
      m_ovf  = 0;
      m_dcnt = 0;
    end else begin
      sz   = m_fq.size();
      hs   = (m_rem > 0) && (bus.uo_ready == 1'b1);
      wr   = (bus.y_valid == 1'b1) && (sz < DEPTH);
      drop = (bus.y_valid == 1'b1) && (sz == DEPTH);
      pop  = (sz > 0) && ((m_rem == 0) || ((m_rem == 1) && hs));
      if (pop) begin
        void'(m_fq.pop_front());
        m_rem = 2;
      end else if (hs) begin
        m_rem = m_rem - 1;
      end
      if (wr) begin
        m_fq.push_back(int'(bus.y_n));
        v = s16(int'(bus.y_n));
        exp_q.push_back(v >> 8);
        exp_q.push_back(256 | (v & 255));
      end
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (clr_ovf) m_dcnt = drop ? 1 : 0;
      else if (drop && m_dcnt < 255) m_dcnt = m_dcnt + 1;
    end
  end

  // Monitor: status every cycle, bytes on each handshake
  always @(negedge clk) begin : monitor
    int e;
    if (reset_n) begin
      check("uo_valid", int'(bus.uo_valid), int'(m_rem > 0));
      check("fifo_empty", int'(fifo_empty), int'(m_fq.size() == 0));
      check("fifo_full", int'(fifo_full), int'(m_fq.size() == DEPTH));
      check("overflow", int'(overflow), m_ovf);
      check("drop_cnt", int'(drop_cnt), exp_dcnt());
      if (bus.uo_valid) check("uo_last_state", int'(bus.uo_last), int'(m_rem == 1));
      if (bus.uo_valid && bus.uo_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", int'(bus.uo_data), -1);
        end else begin
          e = exp_q.pop_front();
          check("byte_data", int'(bus.uo_data), e & 255);
          check("byte_last", int'(bus.uo_last), e >> 8);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [YW-1:0] y);
    bus.y_n     = y;
    bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bus.uo_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (m_fq.size() == 0 && m_rem == 0 && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    check("drain_done", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.y_n      = '0;
    bus.y_valid  = 1'b0;
    bus.uo_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_uo_valid", int'(bus.uo_valid), 0);
    check("rst_uo_data", int'(bus.uo_data), 0);
    check("rst_uo_last", int'(bus.uo_last), 0);
    check("rst_fifo_empty", int'(fifo_empty), 1);
    check("rst_fifo_full", int'(fifo_full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    tick();

    // Single samples with latency check
    bus.uo_ready = 1'b1;
    push(14'h3FFF);
    @(negedge clk);
    check("lat_not_yet", int'(bus.uo_valid), 0);
    tick();
    check("lat_valid", int'(bus.uo_valid), 1);
    check("lat_hi_byte", int'(bus.uo_data), 8'hFF);
    tick();
    push(14'h0123);
    drain();

    // Backpressure holds the HI byte of -8192
    bus.uo_ready = 1'b0;
    push(14'h2000);
    tick();
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", int'(bus.uo_valid), 1);
      check("stall_data", int'(bus.uo_data), 8'hE0);
      check("stall_last", int'(bus.uo_last), 0);
    end
    tick();
    drain();

    // Fill and overflow: six back-to-back samples, one lands in the hold register
    bus.uo_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(YW'(i * 37));
    @(negedge clk);
    check("fill_overflow", int'(overflow), 1);
    check("fill_full", int'(fifo_full), 1);
    check("fill_drop_cnt", int'(drop_cnt), exp_dcnt());
    tick();
    drain();

    // Reset in the middle of a transfer
    bus.uo_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(YW'($urandom()));
    tick();
    check("pre_rst_valid", int'(bus.uo_valid), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.uo_valid), 0);
    check("mid_rst_empty", int'(fifo_empty), 1);
    check("mid_rst_overflow", int'(overflow), 0);
    tick();
    reset_n = 1'b1;
    bus.uo_ready = 1'b1;
    repeat (5) tick();
    check("post_rst_idle", int'(bus.uo_valid), 0);

    // Back-to-back: a sample every two clocks with the consumer always ready
    bus.uo_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(YW'($urandom()));
      tick();
    end
    drain();
    check("b2b_no_drop", int'(overflow), 0);

    // clr_ovf against drops
    bus.uo_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(YW'($urandom()));
    bus.y_valid = 1'b1;
    clr_ovf     = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    clr_ovf     = 1'b0;
    @(negedge clk);
    check("clr_drop_ovf", int'(overflow), 1);
    check("clr_drop_cnt", int'(drop_cnt), exp_dcnt());
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_only_ovf", int'(overflow), 0);
    check("clr_only_cnt", int'(drop_cnt), 0);
    tick();
    bus.y_valid = 1'b1;
    repeat (300) tick();
    bus.y_valid = 1'b0;
    @(negedge clk);
    check("sat_overflow", int'(overflow), 1);
`ifdef FIR_OUT_DROP_CNT_EN
    check("sat_drop_cnt", int'(drop_cnt), 255);
`else
    check("sat_drop_cnt", int'(drop_cnt), 0);
`endif
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.y_n      = YW'($urandom());
      bus.y_valid  = ($urandom_range(0, 99) < 45);
      bus.uo_ready = ($urandom_range(0, 99) < 55);
      clr_ovf      = ($urandom_range(0, 99) < 3);
      tick();
    end
    bus.y_valid = 1'b0;
    clr_ovf     = 1'b0;
    drain();
    check("final_fifo_empty", int'(fifo_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
